// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer for the external 5-bit ALU: holds a small register file,
// drives registered ALU inputs for one cycle, then writes the result back.
module alu_op_sequencer #(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned AW     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [2:0]        i_in_op,
  input  logic [AW-1:0]     i_in_rd,
  input  logic [AW-1:0]     i_in_rs,
  input  logic [AW-1:0]     i_in_rt,
  input  logic              i_in_usec,
  input  logic [DATA_W-1:0] i_in_imm,
  output logic [3:0]        o_alu_sel,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic              o_alu_cin,
  input  logic [DATA_W-1:0] i_alu_sum,
  input  logic              i_alu_cout,
  output logic              o_res_valid,
  output logic [DATA_W-1:0] o_res_data,
  output logic [AW-1:0]     o_res_addr,
  output logic              o_cflag,
  input  logic [AW-1:0]     i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data_c
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd4;
  localparam logic [2:0] OP_CLRC = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_is_alu;

  logic [DATA_W-1:0]   r_regs [NREGS];
  logic [AW-1:0]       r_rd;
  logic                r_cflag;
  logic                r_in_ready;
  logic [3:0]          r_alu_sel;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic                r_alu_cin;
  logic                r_res_valid;
  logic [DATA_W-1:0]   r_res_data;
  logic [AW-1:0]       r_res_addr;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and acceptance decode; ops 000..011 go through the ALU
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_is_alu    = (i_in_op[2] == 1'b0);
    case (r_state)
      ST_IDLE: begin
        if (i_in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_is_alu ? ST_ISSUE : ST_WB;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WB;
      ST_WB:    w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: register file, carry flag, ALU drive and result reporting
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
      r_rd        <= '0;
      r_cflag     <= 1'b0;
      r_in_ready  <= 1'b0;
      r_alu_sel   <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_cin   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_addr  <= '0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_res_valid <= 1'b0;
      if (w_accept) begin
        r_rd <= i_in_rd;
        if (w_is_alu) begin
          r_alu_sel <= {1'b0, i_in_op};
          r_alu_a   <= r_regs[i_in_rs];
          r_alu_b   <= r_regs[i_in_rt];
          r_alu_cin <= i_in_usec & r_cflag;
        end else if (i_in_op == OP_LDI) begin
          r_regs[i_in_rd] <= i_in_imm;
          r_res_valid     <= 1'b1;
          r_res_data      <= i_in_imm;
          r_res_addr      <= i_in_rd;
        end else if (i_in_op == OP_CLRC) begin
          r_cflag <= 1'b0;
        end
      end
      if (r_state == ST_ISSUE) begin
        r_regs[r_rd] <= i_alu_sum;
        r_res_valid  <= 1'b1;
        r_res_data   <= i_alu_sum;
        r_res_addr   <= r_rd;
        if (r_alu_sel == 4'(OP_ADD)) begin
          r_cflag <= i_alu_cout;
        end
      end
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_alu_sel    = r_alu_sel;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_cin    = r_alu_cin;
  assign o_res_valid  = r_res_valid;
  assign o_res_data   = r_res_data;
  assign o_res_addr   = r_res_addr;
  assign o_cflag      = r_cflag;
  assign o_dbg_data_c = r_regs[i_dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 5-bit ALU attached to its ALU ports.
module tb_alu_op_sequencer;

  localparam int unsigned DATA_W = 5;
  localparam int unsigned NREGS  = 4;
  localparam int unsigned AW     = 2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_LDI  = 3'd4;
  localparam logic [2:0] OP_CLRC = 3'd5;
  localparam logic [2:0] OP_RSV  = 3'd6;

  logic              clk;
  logic              rst_n;
  logic              i_in_valid;
  logic              o_in_ready;
  logic [2:0]        i_in_op;
  logic [AW-1:0]     i_in_rd;
  logic [AW-1:0]     i_in_rs;
  logic [AW-1:0]     i_in_rt;
  logic              i_in_usec;
  logic [DATA_W-1:0] i_in_imm;
  logic [3:0]        o_alu_sel;
  logic [DATA_W-1:0] o_alu_a;
  logic [DATA_W-1:0] o_alu_b;
  logic              o_alu_cin;
  logic [DATA_W-1:0] w_alu_sum;
  logic              w_alu_cout;
  logic              o_res_valid;
  logic [DATA_W-1:0] o_res_data;
  logic [AW-1:0]     o_res_addr;
  logic              o_cflag;
  logic [AW-1:0]     i_dbg_addr;
  logic [DATA_W-1:0] o_dbg_data_c;

  int n_cmp;
  int n_err;

  alu_op_sequencer #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_op      (i_in_op),
    .i_in_rd      (i_in_rd),
    .i_in_rs      (i_in_rs),
    .i_in_rt      (i_in_rt),
    .i_in_usec    (i_in_usec),
    .i_in_imm     (i_in_imm),
    .o_alu_sel    (o_alu_sel),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_cin    (o_alu_cin),
    .i_alu_sum    (w_alu_sum),
    .i_alu_cout   (w_alu_cout),
    .o_res_valid  (o_res_valid),
    .o_res_data   (o_res_data),
    .o_res_addr   (o_res_addr),
    .o_cflag      (o_cflag),
    .i_dbg_addr   (i_dbg_addr),
    .o_dbg_data_c (o_dbg_data_c)
  );

  // ALU model: SUB reports borrow in COUT so a wrongly loaded flag is visible
  logic [DATA_W:0] w_alu_full;
  always_comb begin
    w_alu_full = '0;
    case (o_alu_sel)
      4'd0:    w_alu_full = {1'b0, o_alu_a} + {1'b0, o_alu_b} + (DATA_W+1)'(o_alu_cin);
      4'd1:    w_alu_full = {1'b0, o_alu_a} - {1'b0, o_alu_b} - (DATA_W+1)'(o_alu_cin);
      4'd2:    w_alu_full = {1'b0, o_alu_a ^ o_alu_b};
      4'd3:    w_alu_full = {1'b0, o_alu_a & o_alu_b};
      default: w_alu_full = '0;
    endcase
  end
  assign w_alu_sum  = w_alu_full[DATA_W-1:0];
  assign w_alu_cout = w_alu_full[DATA_W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [AW-1:0] a, input logic [DATA_W-1:0] exp);
    i_dbg_addr = a;
    #1;
    chk(tag, 32'(o_dbg_data_c), 32'(exp));
  endtask

  // Present an op and wait (bounded) for acceptance; returns 1ns after the accepting edge
  task automatic send(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                      input logic [AW-1:0] rt, input logic usec, input logic [DATA_W-1:0] imm);
    int n;
    n = 0;
    @(negedge clk);
    i_in_op    = op;
    i_in_rd    = rd;
    i_in_rs    = rs;
    i_in_rt    = rt;
    i_in_usec  = usec;
    i_in_imm   = imm;
    i_in_valid = 1'b1;
    while (o_in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(o_in_ready), 32'(1));
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  task automatic ldi(input logic [AW-1:0] rd, input logic [DATA_W-1:0] imm);
    send(OP_LDI, rd, '0, '0, 1'b0, imm);
    chk("ldi_res_valid", 32'(o_res_valid), 32'(1));
    chk("ldi_res_data", 32'(o_res_data), 32'(imm));
    chk("ldi_res_addr", 32'(o_res_addr), 32'(rd));
    chk_reg("ldi_dbg", rd, imm);
    @(posedge clk);
    #1;
    chk("ldi_res_clear", 32'(o_res_valid), 32'(0));
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input logic usec,
                        input logic [DATA_W-1:0] exp_a, input logic [DATA_W-1:0] exp_b,
                        input logic exp_cin, input logic [DATA_W-1:0] exp_res);
    send(op, rd, rs, rt, usec, '0);
    chk("issue_ready", 32'(o_in_ready), 32'(0));
    chk("issue_res_valid", 32'(o_res_valid), 32'(0));
    chk("alu_sel", 32'(o_alu_sel), 32'({1'b0, op}));
    chk("alu_a", 32'(o_alu_a), 32'(exp_a));
    chk("alu_b", 32'(o_alu_b), 32'(exp_b));
    chk("alu_cin", 32'(o_alu_cin), 32'(exp_cin));
    @(posedge clk);
    #1;
    chk("wb_res_valid", 32'(o_res_valid), 32'(1));
    chk("wb_res_data", 32'(o_res_data), 32'(exp_res));
    chk("wb_res_addr", 32'(o_res_addr), 32'(rd));
    chk("wb_alu_a_held", 32'(o_alu_a), 32'(exp_a));
    chk_reg("wb_dbg", rd, exp_res);
    @(posedge clk);
    #1;
    chk("idle_res_clear", 32'(o_res_valid), 32'(0));
    chk("idle_ready", 32'(o_in_ready), 32'(1));
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    i_in_valid = 1'b0;
    i_in_op    = '0;
    i_in_rd    = '0;
    i_in_rs    = '0;
    i_in_rt    = '0;
    i_in_usec  = 1'b0;
    i_in_imm   = '0;
    i_dbg_addr = '0;

    // Reset state
    #12;
    chk("rst_ready", 32'(o_in_ready), 32'(0));
    chk("rst_res_valid", 32'(o_res_valid), 32'(0));
    chk("rst_res_data", 32'(o_res_data), 32'(0));
    chk("rst_cflag", 32'(o_cflag), 32'(0));
    chk("rst_alu_sel", 32'(o_alu_sel), 32'(0));
    chk("rst_alu_a", 32'(o_alu_a), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(o_in_ready), 32'(1));
    chk("post_rst_res_valid", 32'(o_res_valid), 32'(0));
    chk("post_rst_cflag", 32'(o_cflag), 32'(0));
    for (int i = 0; i < int'(NREGS); i++) chk_reg("rst_reg", AW'(i), '0);

    // 7 + 9 = 16
    ldi(2'd0, 5'd7);
    ldi(2'd1, 5'd9);
    alu_op(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 5'd7, 5'd9, 1'b0, 5'd16);
    chk("add1_cflag", 32'(o_cflag), 32'(0));

    // 31 + 1 wraps to 0 with carry; then 31 + 31 + 1 = 63 -> 31, carry stays set
    ldi(2'd0, 5'd31);
    ldi(2'd1, 5'd1);
    alu_op(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 5'd31, 5'd1, 1'b0, 5'd0);
    chk("add2_cflag", 32'(o_cflag), 32'(1));
    alu_op(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 5'd31, 5'd31, 1'b1, 5'd31);
    chk("add3_cflag", 32'(o_cflag), 32'(1));

    // SUB leaves the carry flag alone
    ldi(2'd0, 5'd5);
    ldi(2'd1, 5'd3);
    alu_op(OP_SUB, 2'd2, 2'd0, 2'd1, 1'b0, 5'd5, 5'd3, 1'b0, 5'd2);
    chk("sub_cflag", 32'(o_cflag), 32'(1));

    // CLRC clears the flag with no result pulse
    send(OP_CLRC, 2'd0, '0, '0, 1'b0, '0);
    chk("clrc_cflag", 32'(o_cflag), 32'(0));
    chk("clrc_no_res", 32'(o_res_valid), 32'(0));
    @(posedge clk);
    #1;
    chk("clrc_ready", 32'(o_in_ready), 32'(1));

    // USEC with a clear flag gives CIN = 0
    alu_op(OP_ADD, 2'd3, 2'd0, 2'd1, 1'b1, 5'd5, 5'd3, 1'b0, 5'd8);

    // Reserved op: no write, no pulse
    send(OP_RSV, 2'd0, '0, '0, 1'b0, 5'd17);
    chk("rsv_no_res", 32'(o_res_valid), 32'(0));
    chk_reg("rsv_r0", 2'd0, 5'd5);
    @(posedge clk);
    #1;

    // XOR with RS=RT=RD samples old operand
    ldi(2'd1, 5'd21);
    alu_op(OP_XOR, 2'd1, 2'd1, 2'd1, 1'b0, 5'd21, 5'd21, 1'b0, 5'd0);
    ldi(2'd0, 5'd22);
    ldi(2'd3, 5'd13);
    alu_op(OP_AND, 2'd0, 2'd0, 2'd3, 1'b0, 5'd22, 5'd13, 1'b0, 5'd4);

    // Reset during ISSUE aborts the write
    ldi(2'd0, 5'd4);
    ldi(2'd1, 5'd6);
    send(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(o_in_ready), 32'(0));
    @(posedge clk);
    #1;
    chk("midrst_no_res", 32'(o_res_valid), 32'(0));
    chk_reg("midrst_r2", 2'd2, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_back", 32'(o_in_ready), 32'(1));
    chk("midrst_no_res2", 32'(o_res_valid), 32'(0));
    chk_reg("midrst_r2_after", 2'd2, 5'd0);

    // IN_VALID held through ISSUE/WB is only accepted back in IDLE
    ldi(2'd0, 5'd4);
    ldi(2'd1, 5'd6);
    send(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, '0);
    i_in_op    = OP_LDI;
    i_in_rd    = 2'd3;
    i_in_imm   = 5'd11;
    i_in_valid = 1'b1;
    chk("hold_issue_ready", 32'(o_in_ready), 32'(0));
    @(posedge clk);
    #1;
    chk("hold_wb_valid", 32'(o_res_valid), 32'(1));
    chk("hold_wb_data", 32'(o_res_data), 32'(10));
    chk("hold_wb_addr", 32'(o_res_addr), 32'(2));
    chk_reg("hold_wb_r3", 2'd3, 5'd0);
    @(posedge clk);
    #1;
    chk("hold_idle_ready", 32'(o_in_ready), 32'(1));
    chk("hold_idle_no_res", 32'(o_res_valid), 32'(0));
    chk_reg("hold_idle_r3", 2'd3, 5'd0);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    chk("hold_ldi_valid", 32'(o_res_valid), 32'(1));
    chk("hold_ldi_addr", 32'(o_res_addr), 32'(3));
    chk("hold_ldi_data", 32'(o_res_data), 32'(11));
    chk_reg("hold_ldi_r3", 2'd3, 5'd11);
    @(posedge clk);
    #1;
    chk("final_ready", 32'(o_in_ready), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream issue and writeback stage for the 5-bit ALU.
- Accepts one operation at a time over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU's select, operand and carry-in inputs from registers, then writes the ALU result back to the destination register.
- Keeps a carry flag so that multi-word add chains are possible.

Parameters:
- DATA_W, 5, operand/result width; must match the ALU width.
- NREGS, 4, register-file depth; must be a power of two.
- AW, 2, register address width; equals log2(NREGS).

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  operation request.
- IN_READY  out  1  sequencer can accept an operation.
- IN_OP  in  3  000 ADD, 001 SUB, 010 XOR, 011 AND, 100 LDI, 101 CLRC, others reserved.
- IN_RD  in  AW  destination register.
- IN_RS  in  AW  operand A register.
- IN_RT  in  AW  operand B register.
- IN_USEC  in  1  1 means CIN = carry flag; 0 means CIN = 0.
- IN_IMM  in  DATA_W  immediate value for LDI.
- ALU_SEL  out  4  to ALU MUX_SELECT.
- ALU_A  out  DATA_W  to ALU A.
- ALU_B  out  DATA_W  to ALU B.
- ALU_CIN  out  1  to ALU CIN.
- ALU_SUM  in  DATA_W  from ALU SUM.
- ALU_COUT  in  1  from ALU COUT.
- RES_VALID  out  1  one-cycle pulse when a write to the register file completes.
- RES_DATA  out  DATA_W  value written.
- RES_ADDR  out  AW  register written.
- CFLAG  out  1  current carry flag.
- DBG_ADDR  in  AW  debug read address.
- DBG_DATA  out  DATA_W  combinational read of REG[DBG_ADDR].

Behaviour:
- Reset (asynchronous, RST_N low):
  - State = IDLE.
  - All registers = 0, CFLAG = 0.
  - ALU_SEL/A/B/CIN = 0.
  - RES_VALID = 0, RES_DATA = 0, RES_ADDR = 0.
  - IN_READY = 0 while reset is asserted.
  - A reset mid-operation aborts it; no write occurs.
- FSM states: IDLE, ISSUE, WB.
- IDLE:
  - IN_READY = 1.
  - If IN_VALID=1, latch op and RD, and go to the next state:
    - ADD/SUB/XOR/AND: load ALU_SEL = {1'b0, OP}, ALU_A = REG[RS], ALU_B = REG[RT], ALU_CIN = IN_USEC & CFLAG; go to ISSUE.
    - LDI: write IN_IMM to REG[RD] on this edge; go to WB.
    - CLRC: CFLAG cleared on this edge; go to WB.
    - Reserved op: treated as a no-op; go to WB.
- ISSUE:
  - IN_READY = 0.
  - ALU inputs are stable for the whole cycle.
  - At the end of the cycle, write ALU_SUM to REG[RD].
  - CFLAG is loaded with ALU_COUT for ADD only; SUB/XOR/AND leave CFLAG unchanged.
  - Go to WB.
- WB:
  - IN_READY = 0.
  - RES_VALID = 1 for exactly this cycle, with RES_DATA/RES_ADDR equal to the value and register just written.
  - For no-op and CLRC: RES_VALID = 0 in WB.
  - Always return to IDLE.
- ALU_* outputs hold their last values outside ISSUE; they are not cleared.
- Throughput and latency:
  - ALU ops: 3 cycles per operation; RES_VALID is asserted 2 cycles after acceptance.
  - LDI: RES_VALID is asserted 1 cycle after acceptance.
- Hazards:
  - RS or RT equal to RD is legal; operands are sampled before the write.
  - Back-to-back dependent ops see the updated value because a WB cycle always separates them.
- Arithmetic: width wrap is the ALU's behaviour; the sequencer performs no arithmetic, and results are truncated to DATA_W.
- DBG_DATA reflects a write on the cycle after the write edge.
- Simultaneous events: IN_VALID asserted while not in IDLE is ignored and not latched; the requester must hold IN_VALID until IN_READY is seen.

Test Plan:
- Reset, then release:
  - Every register reads 0 via DBG.
  - CFLAG = 0, RES_VALID = 0.
  - IN_READY = 1 the first cycle after RST_N rises.
- LDI R0=7, LDI R1=9, then ADD R2=R0+R1 with USEC=0:
  - ALU_SEL = 0000, A = 7, B = 9, CIN = 0 during ISSUE.
  - RES_VALID pulse with RES_DATA = 16, RES_ADDR = 2.
  - CFLAG = 0.
- LDI R0=31, LDI R1=1, then ADD R2 with USEC=0:
  - R2 = 0, CFLAG = 1.
  - Then ADD R3=R0+R0 with USEC=1: CIN = 1, R3 = 31 (63 mod 32), CFLAG = 1.
- SUB R0-R1 with R0=5, R1=3, CFLAG=1 (set beforehand):
  - CFLAG stays 1.
  - Then CLRC: CFLAG = 0 and no RES_VALID pulse.
- XOR R1=R1^R1 with R1=21: R1 = 0, RES_ADDR = 1. Then AND R0 with 22&13: result 4.
- Reset mid-ISSUE:
  - Assert RST_N=0 during ISSUE of ADD R2: R2 stays 0, no RES_VALID pulse.
  - IN_VALID held high during ISSUE/WB is accepted only on return to IDLE.
